// File: rtl/rob_retire_recover_pkg.sv
// Shared types and default sizing for the reorder buffer retire/recover block.
package rob_retire_recover_pkg;

  localparam int ROB_WAYS  = 3;
  localparam int ROB_DEPTH = 32;
  localparam int ROB_AR_W  = 5;
  localparam int ROB_PR_W  = 6;
  localparam int ROB_XLEN  = 32;

  // Field widths follow the package defaults; change them here to resize the entry.
  typedef struct packed {
    logic                valid;
    logic                complete;
    logic                mispredict;
    logic [ROB_AR_W-1:0] ar_idx;
    logic [ROB_PR_W-1:0] t_idx;
    logic [ROB_PR_W-1:0] told_idx;
    logic [ROB_XLEN-1:0] target_pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_arch_map.sv
// Architectural register map: identity after reset, updated by up to WAYS retiring writes per cycle.
module rob_arch_map
  import rob_retire_recover_pkg::*;
#(
  parameter int WAYS = ROB_WAYS,
  parameter int AR_W = ROB_AR_W,
  parameter int PR_W = ROB_PR_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WAYS-1:0]           wr_en,
  input  logic [WAYS*AR_W-1:0]      wr_ar,
  input  logic [WAYS*PR_W-1:0]      wr_t,
  output logic [(2**AR_W)*PR_W-1:0] map
);

  localparam int NREG = 2**AR_W;

  logic [PR_W-1:0] map_q [NREG];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) map_q[r] <= PR_W'(r);
    end else begin
      // NOTE: non-blocking writes issued in way order, so the last (highest, youngest) way wins on a duplicate ar_idx.
      for (int i = 0; i < WAYS; i++) begin
        if (wr_en[i] && (wr_ar[i*AR_W +: AR_W] != '0))
          map_q[wr_ar[i*AR_W +: AR_W]] <= wr_t[i*PR_W +: PR_W];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) map[r*PR_W +: PR_W] = map_q[r];
  end

endmodule

// File: rtl/rob_retire_recover.sv
// N-way reorder buffer: dispatch allocation, completion marking, in-order retire with
// told-register release, architectural map update and precise mispredict recovery.
module rob_retire_recover
  import rob_retire_recover_pkg::*;
#(
  parameter int WAYS   = ROB_WAYS,
  parameter int DEPTH  = ROB_DEPTH,
  parameter int AR_W   = ROB_AR_W,
  parameter int PR_W   = ROB_PR_W,
  parameter int XLEN   = ROB_XLEN,
  parameter int RIDX_W = $clog2(DEPTH),
  parameter int FREE_W = $clog2(WAYS + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WAYS-1:0]           disp_valid,
  input  logic [WAYS*AR_W-1:0]      disp_ar_idx,
  input  logic [WAYS*PR_W-1:0]      disp_t_idx,
  input  logic [WAYS*PR_W-1:0]      disp_told_idx,
  output logic [FREE_W-1:0]         disp_free_slots,
  output logic [WAYS*RIDX_W-1:0]    disp_rob_idx,
  input  logic [WAYS-1:0]           cmp_valid,
  input  logic [WAYS*RIDX_W-1:0]    cmp_rob_idx,
  input  logic [WAYS-1:0]           cmp_mispredict,
  input  logic [WAYS*XLEN-1:0]      cmp_target_pc,
  output logic [WAYS-1:0]           ret_valid,
  output logic [WAYS*AR_W-1:0]      ret_ar_idx,
  output logic [WAYS*PR_W-1:0]      ret_t_idx,
  output logic [WAYS*PR_W-1:0]      ret_told_idx,
  output logic                      br_recover,
  output logic [XLEN-1:0]           recover_pc,
  output logic [(2**AR_W)*PR_W-1:0] arch_map,
  output logic [RIDX_W:0]           rob_count
);

  typedef logic [RIDX_W:0] ptr_t;

  ptr_t              head_q, tail_q, count_q;
  rob_entry_t        rob_q [DEPTH];
  logic [WAYS-1:0]   accept;
  ptr_t              n_accept, n_retire;
  logic [RIDX_W-1:0] disp_slot [WAYS];
  logic [RIDX_W-1:0] ret_slot  [WAYS];

  assign rob_count = count_q;

  // Free slots come from the registered count only; same-cycle retires are not credited.
  always_comb begin
    ptr_t room;
    logic open;
    room = ptr_t'(DEPTH) - count_q;
    if (room >= ptr_t'(WAYS)) disp_free_slots = FREE_W'(WAYS);
    else                      disp_free_slots = FREE_W'(room);
    accept       = '0;
    n_accept     = '0;
    open         = 1'b1;
    disp_rob_idx = '0;
    for (int i = 0; i < WAYS; i++) begin
      disp_slot[i] = tail_q[RIDX_W-1:0] + RIDX_W'(i);
      disp_rob_idx[i*RIDX_W +: RIDX_W] = disp_slot[i];
      if (open && disp_valid[i] && (i < int'(disp_free_slots))) begin
        accept[i] = 1'b1;
        n_accept  = n_accept + ptr_t'(1);
      end else begin
        open = 1'b0;
      end
    end
  end

  // Retire scan from head; a mispredicted entry retires and ends the group.
  always_comb begin
    logic stop;
    logic [RIDX_W-1:0] slot;
    // NOTE: every output and local gets a default before the loop, so no latch is inferred.
    stop         = 1'b0;
    ret_valid    = '0;
    ret_ar_idx   = '0;
    ret_t_idx    = '0;
    ret_told_idx = '0;
    br_recover   = 1'b0;
    recover_pc   = '0;
    n_retire     = '0;
    for (int i = 0; i < WAYS; i++) begin
      slot        = head_q[RIDX_W-1:0] + RIDX_W'(i);
      ret_slot[i] = slot;
      if (!stop && rob_q[slot].valid && rob_q[slot].complete) begin
        ret_valid[i]                   = 1'b1;
        ret_ar_idx[i*AR_W +: AR_W]     = rob_q[slot].ar_idx;
        ret_t_idx[i*PR_W +: PR_W]      = rob_q[slot].t_idx;
        ret_told_idx[i*PR_W +: PR_W]   = rob_q[slot].told_idx;
        n_retire                       = n_retire + ptr_t'(1);
        if (rob_q[slot].mispredict) begin
          stop       = 1'b1;
          br_recover = 1'b1;
          recover_pc = rob_q[slot].target_pc;
        end
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      // NOTE: only the flag bits are reset; payload fields are don't-care until valid is set.
      for (int e = 0; e < DEPTH; e++) begin
        rob_q[e].valid      <= 1'b0;
        rob_q[e].complete   <= 1'b0;
        rob_q[e].mispredict <= 1'b0;
      end
    end else if (br_recover) begin
      // Everything younger than the mispredict is squashed; dispatch and completion are dropped.
      head_q  <= head_q + n_retire;
      tail_q  <= head_q + n_retire;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) rob_q[e].valid <= 1'b0;
    end else begin
      head_q  <= head_q + n_retire;
      tail_q  <= tail_q + n_accept;
      count_q <= count_q + n_accept - n_retire;
      for (int i = 0; i < WAYS; i++) begin
        if (accept[i]) begin
          rob_q[disp_slot[i]] <= '{valid:      1'b1,
                                   complete:   1'b0,
                                   mispredict: 1'b0,
                                   ar_idx:     disp_ar_idx[i*AR_W +: AR_W],
                                   t_idx:      disp_t_idx[i*PR_W +: PR_W],
                                   told_idx:   disp_told_idx[i*PR_W +: PR_W],
                                   target_pc:  '0};
        end
      end
      for (int i = 0; i < WAYS; i++) begin
        if (cmp_valid[i] && rob_q[cmp_rob_idx[i*RIDX_W +: RIDX_W]].valid) begin
          rob_q[cmp_rob_idx[i*RIDX_W +: RIDX_W]].complete   <= 1'b1;
          rob_q[cmp_rob_idx[i*RIDX_W +: RIDX_W]].mispredict <= cmp_mispredict[i];
          rob_q[cmp_rob_idx[i*RIDX_W +: RIDX_W]].target_pc  <= cmp_target_pc[i*XLEN +: XLEN];
        end
      end
      for (int i = 0; i < WAYS; i++) begin
        if (ret_valid[i]) rob_q[ret_slot[i]].valid <= 1'b0;
      end
    end
  end

  rob_arch_map #(
    .WAYS (WAYS),
    .AR_W (AR_W),
    .PR_W (PR_W)
  ) u_arch_map (
    .clock (clock),
    .reset (reset),
    .wr_en (ret_valid),
    .wr_ar (ret_ar_idx),
    .wr_t  (ret_t_idx),
    .map   (arch_map)
  );

endmodule
